// File: rtl/rv_pkg.sv
// Shared RV32 constants and fetch-stage bundle types.
// Imported by the fetch stage and its FIFO.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO with clear, occupancy count and a head word
// read straight from the storage flops.
module inst_fifo
    import rv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        // A full FIFO still takes a push when the head leaves this cycle.
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, response
// buffering and single-cycle redirect with stale-response discard.
module inst_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     inst_count;
    logic [XLEN-1:0]   pend_pc;
    logic [2*XLEN-1:0] head_raw;
    fetch_entry_t      head;
    fetch_entry_t      rsp_entry;
    logic              pend_full, pend_empty;
    logic              inst_full, inst_empty;
    logic              credit_ok, accept, rsp_ok;
    logic              inst_push, inst_pop;
    logic              unused_ok;

    assign unused_ok = &{1'b0, pend_full, inst_full};

    // The pending-PC queue depth is exactly the in-flight request count.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, inst_count})
                       < (CW + 1)'(DEPTH);
    assign imem_req_valid = rst_n && credit_ok && !redirect_valid;
    assign imem_addr      = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && !pend_empty;

    assign rsp_entry.inst = imem_rsp_data;
    assign rsp_entry.pc   = pend_pc;
    assign inst_push = rsp_ok && (discard_q == '0) && !redirect_valid;
    assign inst_pop  = inst_valid && inst_ready && !redirect_valid;

    assign head       = fetch_entry_t'(head_raw);
    assign inst_valid = !inst_empty;
    assign inst       = inst_valid ? head.inst : NOP_INST;
    assign inst_pc    = inst_valid ? head.pc : '0;

    inst_fifo #(
        .WIDTH(XLEN),
        .DEPTH(DEPTH)
    ) u_pend_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .push_data(pc_q),
        .pop      (rsp_ok),
        .clear    (1'b0),
        .full     (pend_full),
        .empty    (pend_empty),
        .count    (outstanding),
        .head     (pend_pc)
    );

    inst_fifo #(
        .WIDTH(2 * XLEN),
        .DEPTH(DEPTH)
    ) u_inst_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inst_push),
        .push_data(rsp_entry),
        .pop      (inst_pop),
        .clear    (redirect_valid),
        .full     (inst_full),
        .empty    (inst_empty),
        .count    (inst_count),
        .head     (head_raw)
    );

    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        if (redirect_valid) begin
            pc_d      = align_pc(redirect_pc);
            discard_d = outstanding - CW'(rsp_ok);
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (rsp_ok && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench: two fetch stages (default and wrapping RESET_PC)
// each fed by an in-order imem model with programmable latency.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rq_v [2];
    logic        rq_r [2];
    logic [31:0] addr [2];
    logic        rsp_v [2];
    logic [31:0] rsp_d [2];
    logic        rd_v [2];
    logic [31:0] rd_pc [2];
    logic        iv [2];
    logic        ir [2];
    logic [31:0] ins [2];
    logic [31:0] ipc [2];

    int          mready [2];
    int          lat [2];
    logic [31:0] maddr [2][16];
    int          mdue [2][16];
    int          mwp [2];
    int          mrp [2];
    logic [31:0] acc_addr [2][1024];
    int          acc_n [2];
    logic [31:0] dl_pc [2][1024];
    logic [31:0] dl_in [2][1024];
    int          dn [2];
    int          cyc = 0;
    int          nerr = 0;
    int          nchk = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(rq_v[0]), .imem_req_ready(rq_r[0]),
        .imem_addr(addr[0]),
        .imem_rsp_valid(rsp_v[0]), .imem_rsp_data(rsp_d[0]),
        .redirect_valid(rd_v[0]), .redirect_pc(rd_pc[0]),
        .inst_valid(iv[0]), .inst_ready(ir[0]),
        .inst(ins[0]), .inst_pc(ipc[0])
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(rq_v[1]), .imem_req_ready(rq_r[1]),
        .imem_addr(addr[1]),
        .imem_rsp_valid(rsp_v[1]), .imem_rsp_data(rsp_d[1]),
        .redirect_valid(rd_v[1]), .redirect_pc(rd_pc[1]),
        .inst_valid(iv[1]), .inst_ready(ir[1]),
        .inst(ins[1]), .inst_pc(ipc[1])
    );

    // Memory model: decisions for the coming rising edge are made here.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rq_r[i] = (mready[i] != 0);
            if (!rst_n) begin
                mrp[i] = mwp[i];
                rsp_v[i] = 1'b0;
                rsp_d[i] = '0;
            end else begin
                if (iv[i] && ir[i] && !rd_v[i] && dn[i] < 1024) begin
                    dl_pc[i][dn[i]] = ipc[i];
                    dl_in[i][dn[i]] = ins[i];
                    dn[i]++;
                end
                if (mrp[i] != mwp[i] && mdue[i][mrp[i] % 16] <= cyc + 1) begin
                    rsp_v[i] = 1'b1;
                    rsp_d[i] = maddr[i][mrp[i] % 16] ^ 32'hA5A5_0000;
                    mrp[i]++;
                end else begin
                    rsp_v[i] = 1'b0;
                    rsp_d[i] = '0;
                end
                if (rq_v[i] && rq_r[i]) begin
                    maddr[i][mwp[i] % 16] = addr[i];
                    mdue[i][mwp[i] % 16] = cyc + 1 + lat[i];
                    if (acc_n[i] < 1024) begin
                        acc_addr[i][acc_n[i]] = addr[i];
                        acc_n[i]++;
                    end
                    mwp[i]++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  nd;
    int  a;
    bit  found;

    initial begin
        for (int i = 0; i < 2; i++) begin
            mready[i] = 1; lat[i] = 1; mwp[i] = 0; mrp[i] = 0;
            acc_n[i] = 0; dn[i] = 0; rd_v[i] = 1'b0; rd_pc[i] = '0;
            rsp_v[i] = 1'b0; rsp_d[i] = '0; rq_r[i] = 1'b1;
        end
        ir[0] = 1'b0;
        ir[1] = 1'b1;
        tick(); tick();
        check("rst_req_valid", rq_v[0], 0);
        check("rst_addr", addr[0], 32'h0);
        check("rst_inst_valid", iv[0], 0);
        check("rst_inst_nop", ins[0], 32'h0000_0013);
        check("rst_inst_pc", ipc[0], 32'h0);
        check("rst_addr_wrap", addr[1], 32'hFFFF_FFF8);
        check("rst_req_valid_wrap", rq_v[1], 0);
        rst_n = 1'b1;
        #1;
        check("rel_req_valid", rq_v[0], 1);
        check("rel_addr", addr[0], 32'h0);
        tick();
        check("e1_addr", addr[0], 32'h4);
        check("e1_inst_valid", iv[0], 0);
        tick();
        check("e2_inst_valid", iv[0], 1);
        check("e2_inst", ins[0], 32'hA5A5_0000);
        check("e2_inst_pc", ipc[0], 32'h0);
        check("e2_req_valid", rq_v[0], 0);
        for (int k = 0; k < 8; k++) tick();
        check("stall_acc_n", acc_n[0], 2);
        check("stall_req_valid", rq_v[0], 0);
        check("stall_addr", addr[0], 32'h8);
        check("stall_inst", ins[0], 32'hA5A5_0000);
        check("stall_inst_pc", ipc[0], 32'h0);
        ir[0] = 1'b1;
        for (int k = 0; k < 20 && dn[0] < 3; k++) tick();
        check("drain_timeout", dn[0] >= 3, 1);
        check("deliv0_pc", dl_pc[0][0], 32'h0);
        check("deliv1_pc", dl_pc[0][1], 32'h4);
        check("deliv2_pc", dl_pc[0][2], 32'h8);
        check("deliv1_inst", dl_in[0][1], 32'hA5A5_0004);
        check("deliv2_inst", dl_in[0][2], 32'hA5A5_0008);
        check("acc2_addr", acc_addr[0][2], 32'h8);
        check("wrap_acc0", acc_addr[1][0], 32'hFFFF_FFF8);
        check("wrap_acc1", acc_addr[1][1], 32'hFFFF_FFFC);
        check("wrap_acc2", acc_addr[1][2], 32'h0);
        check("wrap_pc0", dl_pc[1][0], 32'hFFFF_FFF8);
        check("wrap_pc1", dl_pc[1][1], 32'hFFFF_FFFC);
        check("wrap_pc2", dl_pc[1][2], 32'h0);
        check("wrap_inst0", dl_in[1][0], 32'h5A5A_FFF8);
        check("wrap_inst2", dl_in[1][2], 32'hA5A5_0000);

        mready[0] = 0;
        for (int k = 0; k < 8; k++) tick();
        check("p3_drained", iv[0], 0);
        mready[0] = 1;
        lat[0] = 3;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (mwp[0] - mrp[0] == 2 && mdue[0][mrp[0] % 16] > cyc + 1)
                found = 1;
        end
        check("p3_setup", found, 1);
        nd = dn[0];
        rd_v[0] = 1'b1;
        rd_pc[0] = 32'h0000_0103;
        #1;
        check("p3_no_req", rq_v[0], 0);
        tick();
        rd_v[0] = 1'b0;
        check("p3_addr", addr[0], 32'h100);
        check("p3_inst_valid", iv[0], 0);
        check("p3_discard", dut0.discard_q, 2);
        for (int k = 0; k < 30 && dn[0] <= nd; k++) tick();
        check("p3_timeout", dn[0] > nd, 1);
        check("p3_first_pc", dl_pc[0][nd], 32'h100);
        check("p3_first_inst", dl_in[0][nd], 32'hA5A5_0100);

        mready[0] = 0;
        for (int k = 0; k < 10; k++) tick();
        mready[0] = 1;
        lat[0] = 1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (iv[0] && mwp[0] - mrp[0] == 1 &&
                mdue[0][mrp[0] % 16] == cyc + 1)
                found = 1;
        end
        check("p4_setup", found, 1);
        nd = dn[0];
        rd_v[0] = 1'b1;
        rd_pc[0] = 32'h0000_0200;
        #1;
        check("p4_no_req", rq_v[0], 0);
        tick();
        rd_v[0] = 1'b0;
        check("p4_inst_valid", iv[0], 0);
        check("p4_discard", dut0.discard_q, mwp[0] - mrp[0]);
        check("p4_addr", addr[0], 32'h200);
        check("p4_nothing_popped", dn[0], nd);
        for (int k = 0; k < 20 && dn[0] <= nd; k++) tick();
        check("p4_timeout", dn[0] > nd, 1);
        check("p4_first_pc", dl_pc[0][nd], 32'h200);
        check("p4_first_inst", dl_in[0][nd], 32'hA5A5_0200);

        ir[0] = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("p5_full_valid", iv[0], 1);
        check("p5_full_req", rq_v[0], 0);
        rst_n = 1'b0;
        #1;
        check("p5_rst_valid", iv[0], 0);
        check("p5_rst_nop", ins[0], 32'h0000_0013);
        check("p5_rst_pc", ipc[0], 32'h0);
        check("p5_rst_req", rq_v[0], 0);
        check("p5_rst_addr", addr[0], 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        a = acc_n[0];
        nd = dn[0];
        ir[0] = 1'b1;
        for (int k = 0; k < 20 && dn[0] <= nd; k++) tick();
        check("p5_timeout", dn[0] > nd, 1);
        check("p5_restart_addr", acc_addr[0][a], 32'h0);
        check("p5_restart_pc", dl_pc[0][nd], 32'h0);
        check("p5_restart_inst", dl_in[0][nd], 32'hA5A5_0000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
